// File: rtl/ctrl_drv_pkg.sv
// Shared types and constants for the control-unit stimulus driver.
// CTRL_DRV_ILLEGAL_OP_EN adds the all-zero illegal opcode as a 7th table entry.
package ctrl_drv_pkg;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] OP_ITYPE   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_ILLEGAL = 7'b0000000;

`ifdef CTRL_DRV_ILLEGAL_OP_EN
    localparam int NUM_OPS = 7;
`else
    localparam int NUM_OPS = 6;
`endif

    // 8 funct3 x 2 funct7b5 x 2 Zero combinations per opcode
    localparam int SWEEP_VECS = NUM_OPS * 32;

    // Fibonacci taps 16,14,13,11 expressed on bit indices 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] funct3;
        logic       funct7b5;
        logic       zero;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic       mem_write;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_control;
    } ctrl_rec_t;

    function automatic logic [6:0] op_lookup(input logic [2:0] idx);
        logic [6:0] o;
        case (idx)
            3'd0:    o = OP_LOAD;
            3'd1:    o = OP_STORE;
            3'd2:    o = OP_RTYPE;
            3'd3:    o = OP_ITYPE;
            3'd4:    o = OP_BRANCH;
            3'd5:    o = OP_JAL;
            3'd6:    o = OP_ILLEGAL;
            default: o = OP_LOAD;
        endcase
        return o;
    endfunction

    function automatic logic [2:0] rand_op_idx(input logic [2:0] r);
        logic [2:0] idx;
`ifdef CTRL_DRV_ILLEGAL_OP_EN
        idx = (r == 3'd7) ? 3'd0 : r;
`else
        idx = (r >= 3'd6) ? (r - 3'd6) : r;
`endif
        return idx;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ctrl_stim_driver_if.sv
// Record stream from the stimulus driver to a downstream checker (valid/ready).
interface ctrl_stim_driver_if #(
    parameter int W = 24
);
    logic         rec_valid;
    logic         rec_ready;
    logic [W-1:0] rec_data;

    modport master (
        output rec_valid,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        output rec_ready
    );
endinterface

// File: rtl/ctrl_vec_fifo.sv
// Synchronous FIFO for captured records; pointers carry one wrap bit to split full/empty.
module ctrl_vec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // a pop in the same cycle frees the slot the push lands in
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ctrl_stim_driver.sv
// Drives op/funct3/funct7b5/Zero into a combinational RV32 control unit and queues {stimulus, response}.
// Build option CTRL_DRV_ILLEGAL_OP_EN extends the opcode table (see ctrl_drv_pkg). MAX_VEC_W must be >= 8.
//   state   | meaning
//   IDLE    | waiting for the first start after reset
//   DRIVE   | stimulus registered this edge, DUT settling
//   CAPTURE | push {stimulus, response}; holds while the FIFO is full
//   DONE    | run complete, FIFO may still be draining
module ctrl_stim_driver
    import ctrl_drv_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_VEC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [MAX_VEC_W-1:0] num_vec,
    output logic [6:0]           op,
    output logic                 Zero,
    output logic [2:0]           funct3,
    output logic                 funct7b5,
    input  logic                 Branch,
    input  logic                 Jump,
    input  logic                 MemWrite,
    input  logic                 RegWrite,
    input  logic                 ALUSrc,
    input  logic [1:0]           ResultSrc,
    input  logic [1:0]           ImmSrc,
    input  logic [2:0]           ALUControl,
    ctrl_stim_driver_if.master   rec,
    output logic                 busy,
    output logic                 done,
    output logic [MAX_VEC_W-1:0] vec_cnt
);
    localparam int RW = $bits(ctrl_rec_t);

    state_t               state_q, state_d;
    logic [MAX_VEC_W-1:0] rem_q, rem_d;
    logic [MAX_VEC_W-1:0] vec_cnt_q, vec_cnt_d;
    logic                 mode_q, mode_d;
    logic [6:0]           op_q, op_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 funct7b5_q, funct7b5_d;
    logic                 zero_q, zero_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [7:0]           sweep_idx;

    logic                 start_acc;
    logic                 push;
    logic                 push_ok;
    logic                 load_stim;

    ctrl_rec_t            rec_w;
    logic [RW-1:0]        fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    // a full FIFO whose head is being accepted can still take the new record
    assign push_ok = !fifo_full || rec.rec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DRIVE;
                    start_acc = 1'b1;
                end
            end
            DRIVE:   state_d = (rem_q == '0) ? DONE : CAPTURE;
            CAPTURE: begin
                if (push_ok) state_d = (rem_q == MAX_VEC_W'(1)) ? DONE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        push = 1'b0;
        case (state_q)
            DRIVE:   busy = 1'b1;
            CAPTURE: begin
                busy = 1'b1;
                push = push_ok;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // rem counts down the vectors left in the run; an empty run passes through DRIVE untouched
    always_comb begin
        rem_d     = rem_q;
        vec_cnt_d = vec_cnt_q;
        mode_d    = mode_q;
        if (start_acc) begin
            rem_d     = mode ? num_vec : MAX_VEC_W'(SWEEP_VECS);
            vec_cnt_d = '0;
            mode_d    = mode;
        end else if (push) begin
            rem_d     = rem_q - MAX_VEC_W'(1);
            vec_cnt_d = vec_cnt_q + MAX_VEC_W'(1);
        end
        load_stim = (state_d == DRIVE) && (rem_d != '0);
    end

    // sweep index of the vector being loaded equals the records pushed before it
    always_comb begin
        op_d       = op_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        zero_d     = zero_q;
        lfsr_d     = lfsr_q;
        sweep_idx  = vec_cnt_d[7:0];
        if (load_stim) begin
            if (mode_d) begin
                op_d       = op_lookup(rand_op_idx(lfsr_q[2:0]));
                funct3_d   = lfsr_q[5:3];
                funct7b5_d = lfsr_q[6];
                zero_d     = lfsr_q[7];
                lfsr_d     = lfsr_next(lfsr_q);
            end else begin
                op_d       = op_lookup(sweep_idx[7:5]);
                funct3_d   = sweep_idx[4:2];
                funct7b5_d = sweep_idx[1];
                zero_d     = sweep_idx[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            vec_cnt_q  <= '0;
            mode_q     <= 1'b0;
            op_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            zero_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            rem_q      <= rem_d;
            vec_cnt_q  <= vec_cnt_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            zero_q     <= zero_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign op       = op_q;
    assign funct3   = funct3_q;
    assign funct7b5 = funct7b5_q;
    assign Zero     = zero_q;
    assign vec_cnt  = vec_cnt_q;

    always_comb begin
        rec_w             = '0;
        rec_w.op          = op_q;
        rec_w.funct3      = funct3_q;
        rec_w.funct7b5    = funct7b5_q;
        rec_w.zero        = zero_q;
        rec_w.branch      = Branch;
        rec_w.jump        = Jump;
        rec_w.result_src  = ResultSrc;
        rec_w.mem_write   = MemWrite;
        rec_w.imm_src     = ImmSrc;
        rec_w.reg_write   = RegWrite;
        rec_w.alu_src     = ALUSrc;
        rec_w.alu_control = ALUControl;
    end

    assign fifo_pop = !fifo_empty && rec.rec_ready;

    ctrl_vec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (rec_w),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec.rec_valid = !fifo_empty;
    assign rec.rec_data  = fifo_rdata;

endmodule

// File: tb/tb_ctrl_stim_driver.sv
// Directed bench for ctrl_stim_driver with a behavioural RV32 control unit as the device under stimulus.
module tb_ctrl_stim_driver;

`ifdef CTRL_DRV_ILLEGAL_OP_EN
    localparam int SWEEP = 224;
    localparam logic [6:0] LAST_OP = 7'b0000000;
`else
    localparam int SWEEP = 192;
    localparam logic [6:0] LAST_OP = 7'b1101111;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] num_vec = '0;
    logic [6:0]  op;
    logic        Zero;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Branch, Jump, MemWrite, RegWrite, ALUSrc;
    logic [1:0]  ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic        busy, done;
    logic [15:0] vec_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [23:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] lfsr_m;

    ctrl_stim_driver_if #(.W(24)) rec_if ();

    ctrl_stim_driver #(
        .FIFO_DEPTH (4),
        .LFSR_SEED  (16'hACE1),
        .MAX_VEC_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .num_vec    (num_vec),
        .op         (op),
        .Zero       (Zero),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Branch     (Branch),
        .Jump       (Jump),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .rec        (rec_if),
        .busy       (busy),
        .done       (done),
        .vec_cnt    (vec_cnt)
    );

    always #5 clk = ~clk;

    // single-cycle RV32 main + ALU decoder; returns {Branch,Jump,ResultSrc,MemWrite,ImmSrc,RegWrite,ALUSrc,ALUControl}
    function automatic logic [11:0] ctl_resp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        logic rw, as, mw, br, jp;
        logic [1:0] is, rs, aop;
        logic [2:0] ac;
        {rw, is, as, mw, rs, br, aop, jp} = 11'b0;
        case (o)
            7'b0000011: {rw, is, as, mw, rs, br, aop, jp} = 11'b1_00_1_0_01_0_00_0;
            7'b0100011: {rw, is, as, mw, rs, br, aop, jp} = 11'b0_01_1_1_00_0_00_0;
            7'b0110011: {rw, is, as, mw, rs, br, aop, jp} = 11'b1_00_0_0_00_0_10_0;
            7'b0010011: {rw, is, as, mw, rs, br, aop, jp} = 11'b1_00_1_0_00_0_10_0;
            7'b1100011: {rw, is, as, mw, rs, br, aop, jp} = 11'b0_10_0_0_00_1_01_0;
            7'b1101111: {rw, is, as, mw, rs, br, aop, jp} = 11'b1_11_0_0_10_0_00_1;
            default: ;
        endcase
        case (aop)
            2'b00: ac = 3'b000;
            2'b01: ac = 3'b001;
            default: begin
                case (f3)
                    3'b000:  ac = (o[5] & f7) ? 3'b001 : 3'b000;
                    3'b010:  ac = 3'b101;
                    3'b110:  ac = 3'b011;
                    3'b111:  ac = 3'b010;
                    default: ac = 3'b000;
                endcase
            end
        endcase
        return {br, jp, rs, mw, is, rw, as, ac};
    endfunction

    assign {Branch, Jump, ResultSrc, MemWrite, ImmSrc, RegWrite, ALUSrc, ALUControl} =
        ctl_resp(op, funct3, funct7b5);

    function automatic logic [6:0] tb_op(input int idx);
        case (idx)
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [23:0] mk_rec(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        return {o, f3, f7, z, ctl_resp(o, f3, f7)};
    endfunction

    function automatic logic [23:0] exp_sweep(input int i);
        logic [31:0] v;
        v = i;
        return mk_rec(tb_op(i / 32), v[4:2], v[1], v[0]);
    endfunction

    function automatic int rand_idx(input logic [2:0] r);
`ifdef CTRL_DRV_ILLEGAL_OP_EN
        return (r == 3'd7) ? 0 : int'(r);
`else
        return int'(r) % 6;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // a head seen valid with ready high at the falling edge is popped on the next rising edge
    always @(negedge clk) begin
        if (rst_n && rec_if.rec_valid && rec_if.rec_ready) begin
            got_q.push_back(rec_if.rec_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m, input logic [15:0] n);
        mode    = m;
        num_vec = n;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick(1);
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
    endtask

    task automatic check_sweep(input string tag);
        chk({tag, "_count"}, got_q.size(), SWEEP);
        for (int i = 0; i < SWEEP; i++)
            chk($sformatf("%s_rec%0d", tag, i), got_q[i], exp_sweep(i));
    endtask

    initial begin
        int bad;
        int n;
        logic legal;
        logic [6:0] o;

        rec_if.rec_ready = 1'b1;
        tick(3);
        chk("rst_busy",    busy, 1'b0);
        chk("rst_done",    done, 1'b0);
        chk("rst_valid",   rec_if.rec_valid, 1'b0);
        chk("rst_vec_cnt", vec_cnt, 16'd0);
        chk("rst_stim",    {op, funct3, funct7b5, Zero}, 12'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy",   busy, 1'b0);
        chk("idle_done",   done, 1'b0);
        chk("idle_valid",  rec_if.rec_valid, 1'b0);
        chk("idle_stim",   {op, funct3, funct7b5, Zero}, 12'd0);

        // exhaustive sweep, consumer always ready
        pulse_start(1'b0, 16'd0);
        chk("sweep_busy", busy, 1'b1);
        wait_done("sweep", 1000);
        tick(3);
        chk("sweep_vec_cnt", vec_cnt, SWEEP);
        chk("sweep_idle_busy", busy, 1'b0);
        chk("sweep_drained", rec_if.rec_valid, 1'b0);
        chk("sweep_first", got_q[0][23:12], {7'b0000011, 3'd0, 1'b0, 1'b0});
        chk("sweep_second_zero", got_q[1][23:12], {7'b0000011, 3'd0, 1'b0, 1'b1});
        chk("sweep_last", got_q[SWEEP-1][23:12], {LAST_OP, 3'd7, 1'b1, 1'b1});
`ifdef CTRL_DRV_ILLEGAL_OP_EN
        chk("sweep_illegal_first", got_q[192][23:12], {7'b0000000, 3'd0, 1'b0, 1'b0});
`endif
        check_sweep("sweep");
        bad = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 2) bad++;
        chk("sweep_spacing", bad, 0);

        // backpressure: FIFO fills to 4, vector 4 is held in CAPTURE
        got_q.delete();
        got_cyc.delete();
        rec_if.rec_ready = 1'b0;
        pulse_start(1'b0, 16'd0);
        chk("bp_vec_cnt_restart", vec_cnt, 16'd0);
        tick(20);
        chk("bp_vec_cnt", vec_cnt, 16'd4);
        chk("bp_busy", busy, 1'b1);
        chk("bp_valid", rec_if.rec_valid, 1'b1);
        chk("bp_head", rec_if.rec_data, exp_sweep(0));
        chk("bp_none_popped", got_q.size(), 0);
        chk("bp_stim_held", {op, funct3, funct7b5, Zero}, {7'b0000011, 3'd1, 1'b0, 1'b0});
        tick(5);
        chk("bp_stim_still", {op, funct3, funct7b5, Zero}, {7'b0000011, 3'd1, 1'b0, 1'b0});
        chk("bp_vec_cnt_still", vec_cnt, 16'd4);
        chk("bp_head_stable", rec_if.rec_data, exp_sweep(0));
        rec_if.rec_ready = 1'b1;
        wait_done("bp", 1000);
        tick(8);
        check_sweep("bp");

        // LFSR random run
        got_q.delete();
        lfsr_m = 16'hACE1;
        pulse_start(1'b1, 16'd10);
        wait_done("rand", 200);
        tick(3);
        chk("rand_vec_cnt", vec_cnt, 16'd10);
        chk("rand_count", got_q.size(), 10);
        for (int k = 0; k < 10; k++) begin
            o = tb_op(rand_idx(lfsr_m[2:0]));
            chk($sformatf("rand_rec%0d", k), got_q[k], mk_rec(o, lfsr_m[5:3], lfsr_m[6], lfsr_m[7]));
            legal = 1'b0;
            for (int t = 0; t < 7; t++)
                if (t < SWEEP / 32 && got_q[k][23:17] == tb_op(t)) legal = 1'b1;
            chk($sformatf("rand_legal%0d", k), legal, 1'b1);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end

        // empty random run
        got_q.delete();
        pulse_start(1'b1, 16'd0);
        wait_done("empty", 10);
        tick(3);
        chk("empty_vec_cnt", vec_cnt, 16'd0);
        chk("empty_count", got_q.size(), 0);
        chk("empty_busy", busy, 1'b0);

        // start while busy is ignored, then reset mid-run
        got_q.delete();
        pulse_start(1'b0, 16'd0);
        tick(6);
        pulse_start(1'b1, 16'd3);
        n = 0;
        while (vec_cnt < 16'd50 && n < 500) begin
            tick(1);
            n++;
        end
        chk("mid_reached50", vec_cnt, 16'd50);
        chk("mid_ignore_start", got_q[20], exp_sweep(20));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_vec_cnt", vec_cnt, 16'd0);
        chk("mid_rst_valid", rec_if.rec_valid, 1'b0);
        chk("mid_rst_stim", {op, funct3, funct7b5, Zero}, 12'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        got_q.delete();
        pulse_start(1'b0, 16'd0);
        wait_done("restart", 1000);
        tick(3);
        check_sweep("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
